// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes (MIPS funct), flag bit positions, FSM states.
package alu_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_SLL = 6'h00;
  localparam logic [OP_W-1:0] OP_SRL = 6'h02;
  localparam logic [OP_W-1:0] OP_SRA = 6'h03;
  localparam logic [OP_W-1:0] OP_ADD = 6'h20;
  localparam logic [OP_W-1:0] OP_SUB = 6'h22;
  localparam logic [OP_W-1:0] OP_AND = 6'h24;
  localparam logic [OP_W-1:0] OP_OR  = 6'h25;
  localparam logic [OP_W-1:0] OP_XOR = 6'h26;
  localparam logic [OP_W-1:0] OP_NOR = 6'h27;
  localparam logic [OP_W-1:0] OP_SLT = 6'h2A;

  // Flag vector layout is {N,Z,C,V}
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: (A, B, OP) -> result, {N,Z,C,V} flags and illegal-opcode error.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OPS  = 6
) (
  input  logic [NB_DATA-1:0] a_i,
  input  logic [NB_DATA-1:0] b_i,
  input  logic [NB_OPS-1:0]  op_i,
  output logic [NB_DATA-1:0] res_o,
  output logic [FLAG_W-1:0]  flags_o,
  output logic               err_o
);

  localparam int unsigned SH_W = $clog2(NB_DATA);
  localparam int unsigned MSB  = NB_DATA - 1;

  logic [NB_DATA:0]   sum;
  logic [NB_DATA:0]   diff;
  logic [SH_W-1:0]    sh;
  logic [NB_DATA-1:0] res;
  logic               c;
  logic               v;
  logic               err;

  // One extra bit holds carry-out for ADD and borrow for SUB
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};
  assign sh   = b_i[SH_W-1:0];

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    err = 1'b0;
    case (op_i)
      NB_OPS'(OP_ADD): begin
        res = sum[NB_DATA-1:0];
        c   = sum[NB_DATA];
        v   = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
      end
      NB_OPS'(OP_SUB): begin
        res = diff[NB_DATA-1:0];
        c   = diff[NB_DATA];
        v   = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
      end
      NB_OPS'(OP_AND): res = a_i & b_i;
      NB_OPS'(OP_OR):  res = a_i | b_i;
      NB_OPS'(OP_XOR): res = a_i ^ b_i;
      NB_OPS'(OP_NOR): res = ~(a_i | b_i);
      NB_OPS'(OP_SLT): res = NB_DATA'($signed(a_i) < $signed(b_i));
      NB_OPS'(OP_SLL): res = a_i << sh;
      NB_OPS'(OP_SRL): res = a_i >> sh;
      NB_OPS'(OP_SRA): res = NB_DATA'($signed(a_i) >>> sh);
      default:         err = 1'b1;
    endcase
  end

  always_comb begin
    flags_o = '0;
    if (!err) begin
      flags_o[FLAG_N] = res[MSB];
      flags_o[FLAG_Z] = (res == '0);
      flags_o[FLAG_C] = c;
      flags_o[FLAG_V] = v;
    end
  end

  assign res_o = res;
  assign err_o = err;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU wrapper: operand/opcode latches, start/valid/ready handshake with fixed latency,
// registered result/flags/error, and accumulate mode feeding the last committed result back as A.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OPS  = 6,
  parameter int unsigned LATENCY = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_data,
  input  logic [NB_OPS-1:0]  i_ops,
  input  logic               i_load_a,
  input  logic               i_load_b,
  input  logic               i_load_op,
  input  logic               i_start,
  input  logic               i_acc,
  input  logic               i_ready,
  output logic               o_busy,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_res,
  output logic [FLAG_W-1:0]  o_flags,
  output logic               o_err
);

  localparam int unsigned CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned CNT_LAST = LATENCY - 1;

  state_e             state_q;
  logic [NB_DATA-1:0] a_q;
  logic [NB_DATA-1:0] b_q;
  logic [NB_OPS-1:0]  op_q;
  logic [NB_DATA-1:0] opa_q;
  logic [NB_DATA-1:0] opb_q;
  logic [NB_OPS-1:0]  opx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               valid_q;
  logic [NB_DATA-1:0] res_q;
  logic [FLAG_W-1:0]  flags_q;
  logic               err_q;

  logic [NB_DATA-1:0] opa_d;
  logic [NB_DATA-1:0] core_res;
  logic [FLAG_W-1:0]  core_flags;
  logic               core_err;

  // res_q only changes on entry to DONE, so in IDLE it is the last committed result
  assign opa_d = i_acc ? res_q : a_q;

  alu_core #(
    .NB_DATA (NB_DATA),
    .NB_OPS  (NB_OPS)
  ) u_core (
    .a_i     (opa_q),
    .b_i     (opb_q),
    .op_i    (opx_q),
    .res_o   (core_res),
    .flags_o (core_flags),
    .err_o   (core_err)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      opx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Start captures pre-edge latch contents; a simultaneous load lands for the next op
          if (i_load_a)  a_q  <= i_data;
          if (i_load_b)  b_q  <= i_data;
          if (i_load_op) op_q <= i_ops;
          if (i_start) begin
            opa_q   <= opa_d;
            opb_q   <= b_q;
            opx_q   <= op_q;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_q == CNT_W'(CNT_LAST)) begin
            res_q   <= core_res;
            flags_q <= core_flags;
            err_q   <= core_err;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (valid_q && i_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_res   = res_q;
  assign o_flags = flags_q;
  assign o_err   = err_q;

endmodule
